// File: rtl/y86_fetch.sv
// Y86-64 fetch stage: purely combinational instruction decode.
// Splits the ten fetched bytes into icode, ifun, ra, rb and valC, and computes valP.
// Flags an out-of-range PC or an invalid icode/ifun.
// Reset forces every output to zero immediately, without waiting for a clock edge.
module y86_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC,
  input  logic [0:79] instruct,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        mem_err,
  output logic        instruct_err
);

  // Highest valid byte address of the 1 KiB instruction memory.
  localparam logic [63:0] ImemLast = 64'd1023;

  // clk exists only so every pipeline stage has the same port shape; nothing here is clocked.
  logic w_unused_clk;
  assign w_unused_clk = clk;

  logic [7:0]  w_byte [10];
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_valid;
  logic [63:0] w_len;
  logic        w_has_regs;
  logic [63:0] w_valc;

  // Slice the instruction bytes; byte k is at instruct[8k +: 8], with bit 8k as the MSB.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      w_byte[k] = instruct[8*k +: 8];
    end
  end

  assign w_icode = w_byte[0][7:4];
  assign w_ifun  = w_byte[0][3:0];

  // Check the icode/ifun pair; pick the instruction length, register byte and constant.
  always_comb begin
    w_valid    = 1'b0;
    w_len      = 64'd1;
    w_has_regs = 1'b0;
    w_valc     = 64'd0;
    unique case (w_icode)
      4'h0, 4'h1, 4'h9: begin
        w_valid = (w_ifun == 4'h0);
        w_len   = 64'd1;
      end
      4'h2: begin
        w_valid    = (w_ifun <= 4'h6);
        w_len      = 64'd2;
        w_has_regs = 1'b1;
      end
      4'h6: begin
        w_valid    = (w_ifun <= 4'h3);
        w_len      = 64'd2;
        w_has_regs = 1'b1;
      end
      4'hA, 4'hB: begin
        w_valid    = (w_ifun == 4'h0);
        w_len      = 64'd2;
        w_has_regs = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        w_valid    = (w_ifun == 4'h0);
        w_len      = 64'd10;
        w_has_regs = 1'b1;
        // Little-endian: the lowest-addressed byte becomes the LSB.
        w_valc     = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                      w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
      end
      4'h7: begin
        w_valid = (w_ifun <= 4'h6);
        w_len   = 64'd9;
        w_valc  = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                   w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
      end
      4'h8: begin
        w_valid = (w_ifun == 4'h0);
        w_len   = 64'd9;
        w_valc  = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                   w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // Output select: reset clears everything, then a memory error, then an invalid instruction.
  always_comb begin
    icode        = 4'h0;
    ifun         = 4'h0;
    ra           = 4'h0;
    rb           = 4'h0;
    valC         = 64'd0;
    valP         = 64'd0;
    mem_err      = 1'b0;
    instruct_err = 1'b0;
    if (reset) begin
      // All outputs stay at zero.
    end else if (PC > ImemLast) begin
      // The bytes are meaningless here, so no decode is attempted.
      ra      = 4'hF;
      rb      = 4'hF;
      valP    = PC;
      mem_err = 1'b1;
    end else if (!w_valid) begin
      icode        = w_icode;
      ifun         = w_ifun;
      ra           = 4'hF;
      rb           = 4'hF;
      valP         = PC + 64'd1;
      instruct_err = 1'b1;
    end else begin
      icode = w_icode;
      ifun  = w_ifun;
      ra    = w_has_regs ? w_byte[1][7:4] : 4'hF;
      rb    = w_has_regs ? w_byte[1][3:0] : 4'hF;
      valC  = w_valc;
      valP  = PC + w_len;
    end
  end

endmodule

// File: tb/tb_y86_fetch.sv
// Directed self-checking bench for the combinational Y86 fetch stage.
module tb_y86_fetch;

  logic        clk;
  logic        reset;
  logic [63:0] PC;
  logic [0:79] instruct;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valC, valP;
  logic        mem_err, instruct_err;

  int checks   = 0;
  int failures = 0;

  // Field order: icode, ifun, ra, rb, valC, valP, mem_err, instruct_err.
  wire [145:0] w_got = {icode, ifun, ra, rb, valC, valP, mem_err, instruct_err};
  logic [145:0] exp_v;

  y86_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .instruct     (instruct),
    .icode        (icode),
    .ifun         (ifun),
    .ra           (ra),
    .rb           (rb),
    .valC         (valC),
    .valP         (valP),
    .mem_err      (mem_err),
    .instruct_err (instruct_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [63:0] pc, input logic [0:79] ins);
    @(negedge clk);
    PC       = pc;
    instruct = ins;
    #1;
  endtask

  task automatic test_reset();
    // Reset is checked at time 0, before any clock edge.
    reset    = 1'b1;
    PC       = 64'd34;
    instruct = 80'h40_21_00_00_01_02_03_04_05_06;
    #1;
    checks++;
    if (w_got !== 146'd0) begin
      failures++;
      $display("FAIL reset_initial got=%h exp=%h", w_got, 146'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_long_forms();
    drive(64'd34, 80'h40_21_00_00_01_02_03_04_05_06);
    exp_v = {4'h4, 4'h0, 4'h2, 4'h1, 64'h0605040302010000, 64'd44, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL rmmovq got=%h exp=%h", w_got, exp_v);
    end
    // irmovq with ra=F passed through unchecked.
    drive(64'd100, 80'h30_F4_88_77_66_55_44_33_22_11);
    exp_v = {4'h3, 4'h0, 4'hF, 4'h4, 64'h1122334455667788, 64'd110, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL irmovq got=%h exp=%h", w_got, exp_v);
    end
  endtask

  task automatic test_two_byte();
    drive(64'd62, 80'h61_23_00_00_00_00_00_00_00_00);
    exp_v = {4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd64, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL opq got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd171, 80'hA0_00_FF_FF_FF_FF_FF_FF_FF_FF);
    exp_v = {4'hA, 4'h0, 4'h0, 4'h0, 64'd0, 64'd173, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL pushq got=%h exp=%h", w_got, exp_v);
    end
    // cmovXX ifun=6 is the highest legal value.
    drive(64'd10, 80'h26_AB_00_00_00_00_00_00_00_00);
    exp_v = {4'h2, 4'h6, 4'hA, 4'hB, 64'd0, 64'd12, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL cmov6 got=%h exp=%h", w_got, exp_v);
    end
  endtask

  task automatic test_jump_call();
    drive(64'd90, 80'h71_00_00_00_00_00_00_00_03_00);
    exp_v = {4'h7, 4'h1, 4'hF, 4'hF, 64'h0300000000000000, 64'd99, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL jxx got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd200, 80'h80_EF_CD_AB_89_67_45_23_01_55);
    exp_v = {4'h8, 4'h0, 4'hF, 4'hF, 64'h0123456789ABCDEF, 64'd209, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL call got=%h exp=%h", w_got, exp_v);
    end
  endtask

  task automatic test_one_byte();
    drive(64'd0, 80'h0);
    exp_v = {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL halt got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd5, 80'h90_12_34_00_00_00_00_00_00_00);
    exp_v = {4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd6, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL ret got=%h exp=%h", w_got, exp_v);
    end
  endtask

  task automatic test_invalid();
    drive(64'd66, 80'h35_12_11_22_33_44_55_66_77_88);
    exp_v = {4'h3, 4'h5, 4'hF, 4'hF, 64'd0, 64'd67, 1'b0, 1'b1};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL irmovq_ifun5 got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd66, 80'hC0_12_00_00_00_00_00_00_00_00);
    exp_v = {4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd67, 1'b0, 1'b1};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL icode_c got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd10, 80'h27_AB_00_00_00_00_00_00_00_00);
    exp_v = {4'h2, 4'h7, 4'hF, 4'hF, 64'd0, 64'd11, 1'b0, 1'b1};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL cmov7 got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd20, 80'h64_12_00_00_00_00_00_00_00_00);
    exp_v = {4'h6, 4'h4, 4'hF, 4'hF, 64'd0, 64'd21, 1'b0, 1'b1};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL opq4 got=%h exp=%h", w_got, exp_v);
    end
    drive(64'd30, 80'hB1_45_00_00_00_00_00_00_00_00);
    exp_v = {4'hB, 4'h1, 4'hF, 4'hF, 64'd0, 64'd31, 1'b0, 1'b1};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL popq1 got=%h exp=%h", w_got, exp_v);
    end
  endtask

  task automatic test_mem_err();
    drive(64'd1024, 80'h40_21_00_00_01_02_03_04_05_06);
    exp_v = {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 1'b1, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL pc1024 got=%h exp=%h", w_got, exp_v);
    end
    // Last legal address still decodes.
    drive(64'd1023, 80'h0);
    exp_v = {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL pc1023 got=%h exp=%h", w_got, exp_v);
    end
    // mem_err wins over an invalid opcode.
    drive(64'hFFFF_FFFF_FFFF_FFFF, 80'hC0_00_00_00_00_00_00_00_00_00);
    exp_v = {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL pc_max got=%h exp=%h", w_got, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    drive(64'd62, 80'h61_23_00_00_00_00_00_00_00_00);
    // Assert and release between clock edges.
    reset = 1'b1;
    #1;
    checks++;
    if (w_got !== 146'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", w_got, 146'd0);
    end
    reset = 1'b0;
    #1;
    exp_v = {4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd64, 1'b0, 1'b0};
    checks++;
    if (w_got !== exp_v) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", w_got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_long_forms();
    test_two_byte();
    test_jump_call();
    test_one_byte();
    test_invalid();
    test_mem_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
